// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg -- shared definitions for the framebuffer arbiter slice.
//   PIX_W        : packed RAM pixel width (8 bits each of R, G, B)
//   arb_state_e  : arbiter state, records the grant issued in the previous cycle
//   pack_rgb     : keeps the upper byte of each 16-bit farbfeld channel
// ---------------------------------------------------------------------------
package fb_pkg;
   localparam int PIX_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } arb_state_e;

   function automatic logic [PIX_W-1:0] pack_rgb(input logic [15:0] red,
                                                 input logic [15:0] green,
                                                 input logic [15:0] blue);
      return {red[15:8], green[15:8], blue[15:8]};
   endfunction
endpackage

// File: rtl/fb_arbiter_if.sv
// ---------------------------------------------------------------------------
// fb_arbiter_if -- bundle of the writer, scanout and RAM signals around
// fb_arbiter.
//   slave  : arbiter side (takes requests, drives grants and RAM strobes)
//   master : environment side (pixel writer, scanout reader, RAM read data)
// ---------------------------------------------------------------------------
interface fb_arbiter_if #(parameter int ADDR_W = 19);
   import fb_pkg::*;

   // pixel writer
   logic              wr_valid;
   logic              wr_ready;
   logic [31:0]       wr_row;
   logic [31:0]       wr_col;
   logic [15:0]       wr_red;
   logic [15:0]       wr_green;
   logic [15:0]       wr_blue;
   logic              wr_drop;
   logic              frame_done;
   // scanout reader
   logic              rd_valid;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ready;
   logic [PIX_W-1:0]  rd_data;
   logic              rd_data_valid;
   // single-port RAM
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_wdata;
   logic [PIX_W-1:0]  mem_rdata;

   modport slave (
      input  wr_valid, wr_row, wr_col, wr_red, wr_green, wr_blue,
      input  rd_valid, rd_addr, mem_rdata,
      output wr_ready, wr_drop, frame_done,
      output rd_ready, rd_data, rd_data_valid,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output wr_valid, wr_row, wr_col, wr_red, wr_green, wr_blue,
      output rd_valid, rd_addr, mem_rdata,
      input  wr_ready, wr_drop, frame_done,
      input  rd_ready, rd_data, rd_data_valid,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/fb_wr_buf.sv
// ---------------------------------------------------------------------------
// fb_wr_buf -- one-entry pixel write buffer.
// Converts (row, col) to a linear RAM address, discards out-of-range pixels
// and packs the colour to PIX_W bits.
//   clk, rst     : clock, asynchronous active-high reset
//   i_valid      : writer offers a pixel (accepted when o_ready)
//   i_row/i_col  : pixel coordinates
//   i_red/green/blue : 16-bit colour channels
//   i_wr_gnt     : arbiter grants the buffered write this cycle
//   o_ready      : buffer empty
//   o_full       : buffer holds a pending write
//   o_addr/o_data: buffered address and packed pixel
//   o_drop       : one-cycle pulse after an out-of-range pixel was accepted
// ---------------------------------------------------------------------------
module fb_wr_buf
   import fb_pkg::*;
#(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int ADDR_W = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [31:0]       i_row,
   input  logic [31:0]       i_col,
   input  logic [15:0]       i_red,
   input  logic [15:0]       i_green,
   input  logic [15:0]       i_blue,
   input  logic              i_wr_gnt,
   output logic              o_ready,
   output logic              o_full,
   output logic [ADDR_W-1:0] o_addr,
   output logic [PIX_W-1:0]  o_data,
   output logic              o_drop
);
   logic              r_full;
   logic [ADDR_W-1:0] r_addr;
   logic [PIX_W-1:0]  r_data;
   logic              r_drop;

   logic              w_accept;
   logic              w_oob;
   logic [31:0]       w_lin;

   assign w_accept = i_valid && !r_full;
   assign w_oob    = (i_row >= 32'(IMG_H)) || (i_col >= 32'(IMG_W));
   // in-range pixels always fit in ADDR_W bits, so truncation is lossless
   assign w_lin    = i_row * 32'(IMG_W) + i_col;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
         r_drop <= 1'b0;
      end else begin
         r_drop <= w_accept && w_oob;
         // accept and grant are exclusive: accept needs empty, grant needs full
         if (w_accept && !w_oob) begin
            r_full <= 1'b1;
            r_addr <= w_lin[ADDR_W-1:0];
            r_data <= pack_rgb(i_red, i_green, i_blue);
         end else if (i_wr_gnt) begin
            r_full <= 1'b0;
         end
      end
   end

   assign o_ready = !r_full;
   assign o_full  = r_full;
   assign o_addr  = r_addr;
   assign o_data  = r_data;
   assign o_drop  = r_drop;
endmodule

// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter -- shares one single-port framebuffer RAM between the pixel
// writer and the scanout reader.
// Reads win unless a write has been waiting through STARVE_MAX consecutive
// read grants. RAM strobes are driven combinationally in the grant cycle;
// read data returns one cycle later.
//   clk, rst : clock, asynchronous active-high reset
//   io_bus   : fb_arbiter_if.slave (writer, reader and RAM signals)
// ---------------------------------------------------------------------------
module fb_arbiter
   import fb_pkg::*;
#(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int ADDR_W     = 19,
   parameter int STARVE_MAX = 4
) (
   input  logic         clk,
   input  logic         rst,
   fb_arbiter_if.slave  io_bus
);
   localparam int                CNT_W     = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

   arb_state_e        r_state;
   logic [CNT_W-1:0]  r_starve;
   logic              r_frame_done;

   logic              w_buf_full;
   logic              w_buf_ready;
   logic [ADDR_W-1:0] w_buf_addr;
   logic [PIX_W-1:0]  w_buf_data;
   logic              w_buf_drop;
   logic              w_rd_gnt;
   logic              w_wr_gnt;

   fb_wr_buf #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_wr_buf (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (io_bus.wr_valid),
      .i_row    (io_bus.wr_row),
      .i_col    (io_bus.wr_col),
      .i_red    (io_bus.wr_red),
      .i_green  (io_bus.wr_green),
      .i_blue   (io_bus.wr_blue),
      .i_wr_gnt (w_wr_gnt),
      .o_ready  (w_buf_ready),
      .o_full   (w_buf_full),
      .o_addr   (w_buf_addr),
      .o_data   (w_buf_data),
      .o_drop   (w_buf_drop)
   );

   // grants are masked during reset so no RAM strobe escapes
   always_comb begin
      w_rd_gnt = !rst && io_bus.rd_valid &&
                 (!w_buf_full || (r_starve < CNT_W'(STARVE_MAX)));
      w_wr_gnt = !rst && !w_rd_gnt && w_buf_full;
   end

   always_comb begin
      io_bus.mem_en    = w_rd_gnt || w_wr_gnt;
      io_bus.mem_we    = w_wr_gnt;
      io_bus.mem_addr  = w_wr_gnt ? w_buf_addr : io_bus.rd_addr;
      io_bus.mem_wdata = w_wr_gnt ? w_buf_data : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_starve     <= '0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_rd_gnt)      r_state <= ST_RD;
         else if (w_wr_gnt) r_state <= ST_WR;
         else               r_state <= ST_IDLE;

         // count reads that overtook a pending write
         if (w_wr_gnt || !w_buf_full)
            r_starve <= '0;
         else if (w_rd_gnt && (r_starve < CNT_W'(STARVE_MAX)))
            r_starve <= r_starve + 1'b1;

         r_frame_done <= w_wr_gnt && (w_buf_addr == LAST_ADDR);
      end
   end

   // ST_RD means a read was granted last cycle, so the RAM output is valid now;
   // reset forces IDLE which discards an in-flight return
   assign io_bus.rd_data_valid = (r_state == ST_RD);
   assign io_bus.rd_data       = io_bus.mem_rdata;
   assign io_bus.rd_ready      = w_rd_gnt;
   assign io_bus.wr_ready      = w_buf_ready;
   assign io_bus.wr_drop       = w_buf_drop;
   assign io_bus.frame_done    = r_frame_done;
endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;
   localparam int IMG_W = 4, IMG_H = 2, ADDR_W = 3, STARVE_MAX = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   fb_arbiter_if #(.ADDR_W(ADDR_W)) bus();

   fb_arbiter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX))
      dut (.clk(clk), .rst(rst), .io_bus(bus));

   always #5 clk = ~clk;

   // behavioural single-port RAM, read data one cycle after the strobe
   logic [23:0] ram [8];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata <= ram[bus.mem_addr];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_valid = 0; bus.rd_valid = 0; bus.rd_addr = '0;
      bus.wr_row = 0; bus.wr_col = 0;
      bus.wr_red = 0; bus.wr_green = 0; bus.wr_blue = 0;
   endtask

   task automatic put_pixel(input int row, input int col,
                            input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
      bus.wr_valid = 1; bus.wr_row = row; bus.wr_col = col;
      bus.wr_red = r; bus.wr_green = g; bus.wr_blue = b;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.rd_valid = 1; bus.rd_addr = 3'd2;
      #3;
      checks++; if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b want 0", bus.rd_ready); end
      checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); end
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
      checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rdv: got %b want 0", bus.rd_data_valid); end
      checks++; if ({bus.wr_drop, bus.frame_done} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {bus.wr_drop, bus.frame_done}); end
      checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); end
      tick(); tick();
      idle_inputs();
      rst = 0;
      tick();
   endtask

   task automatic test_write();
      put_pixel(1, 2, 16'hAB00, 16'hCD00, 16'hEF00);
      #1;
      checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL wr_accept_cycle_en: got %b want 0", bus.mem_en); end
      tick();
      idle_inputs();
      #1;
      checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_full: got %b want 0", bus.wr_ready); end
      checks++; if ({bus.mem_en, bus.mem_we} !== 2'b11) begin errors++; $display("FAIL wr_strobes: got %b want 11", {bus.mem_en, bus.mem_we}); end
      checks++; if (bus.mem_addr !== 3'd6) begin errors++; $display("FAIL wr_addr: got %0d want 6", bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 24'hABCDEF) begin errors++; $display("FAIL wr_data: got %h want abcdef", bus.mem_wdata); end
      tick();
      checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_after: got %b want 1", bus.wr_ready); end
      checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL wr_idle_en: got %b want 0", bus.mem_en); end
   endtask

   task automatic test_read();
      bus.rd_valid = 1; bus.rd_addr = 3'd6;
      #1;
      checks++; if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b want 1", bus.rd_ready); end
      checks++; if ({bus.mem_en, bus.mem_we} !== 2'b10) begin errors++; $display("FAIL rd_strobes: got %b want 10", {bus.mem_en, bus.mem_we}); end
      checks++; if (bus.mem_addr !== 3'd6) begin errors++; $display("FAIL rd_addr: got %0d want 6", bus.mem_addr); end
      tick();
      idle_inputs();
      checks++; if (bus.rd_data_valid !== 1'b1) begin errors++; $display("FAIL rd_dv: got %b want 1", bus.rd_data_valid); end
      checks++; if (bus.rd_data !== 24'hABCDEF) begin errors++; $display("FAIL rd_data: got %h want abcdef", bus.rd_data); end
      tick();
      checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL rd_dv_end: got %b want 0", bus.rd_data_valid); end
   endtask

   task automatic test_starve();
      // cycle A: empty buffer, read wins and the pixel is accepted
      logic exp_rd [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      bus.rd_valid = 1; bus.rd_addr = 3'd6;
      put_pixel(0, 1, 16'h1100, 16'h2200, 16'h3300);
      tick();
      bus.wr_valid = 0;
      for (int c = 0; c < 7; c++) begin
         if (c == 3) put_pixel(1, 0, 16'h4400, 16'h5500, 16'h6600);
         else        bus.wr_valid = 0;
         #1;
         checks++;
         if (bus.rd_ready !== exp_rd[c] || bus.mem_we !== !exp_rd[c])
         begin errors++; $display("FAIL starve_seq[%0d]: rd_ready=%b mem_we=%b want rd_ready=%b", c, bus.rd_ready, bus.mem_we, exp_rd[c]); end
         if (c == 2) begin
            checks++;
            if (bus.mem_addr !== 3'd1 || bus.mem_wdata !== 24'h112233)
            begin errors++; $display("FAIL starve_wr: addr=%0d data=%h want 1/112233", bus.mem_addr, bus.mem_wdata); end
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_drop();
      put_pixel(2, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      #1;
      checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL drop_en0: got %b want 0", bus.mem_en); end
      tick();
      idle_inputs();
      #1;
      checks++; if (bus.wr_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b want 1", bus.wr_drop); end
      checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL drop_ready: got %b want 1", bus.wr_ready); end
      checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL drop_en1: got %b want 0", bus.mem_en); end
      tick();
      checks++; if (bus.wr_drop !== 1'b0 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL drop_end: drop=%b en=%b want 0/0", bus.wr_drop, bus.mem_en); end
   endtask

   task automatic test_frame_done();
      put_pixel(1, 3, 16'h0100, 16'h0200, 16'h0300);
      tick();
      idle_inputs();
      #1;
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 3'd7) begin errors++; $display("FAIL fd_grant: we=%b addr=%0d want 1/7", bus.mem_we, bus.mem_addr); end
      checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL fd_early: got %b want 0", bus.frame_done); end
      tick();
      checks++; if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL fd_pulse: got %b want 1", bus.frame_done); end
      tick();
      checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL fd_end: got %b want 0", bus.frame_done); end
   endtask

   task automatic test_reset_mid();
      bus.rd_valid = 1; bus.rd_addr = 3'd6;
      put_pixel(0, 0, 16'h7700, 16'h7700, 16'h7700);
      #1;
      checks++; if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL rm_rd_ready: got %b want 1", bus.rd_ready); end
      tick();
      idle_inputs();
      rst = 1;
      #1;
      checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL rm_dv_in_rst: got %b want 0", bus.rd_data_valid); end
      tick();
      rst = 0;
      #1;
      checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL rm_dv_after: got %b want 0", bus.rd_data_valid); end
      checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rm_buf_empty: got %b want 1", bus.wr_ready); end
      checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rm_idle_en: got %b want 0", bus.mem_en); end
      tick();
      checks++; if (bus.rd_data_valid !== 1'b0 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL rm_idle: dv=%b en=%b want 0/0", bus.rd_data_valid, bus.mem_en); end
   endtask

   // reference model: pending-write slot, starvation count, expected pulses
   task automatic test_random();
      bit          m_full = 0, exp_dv = 0, exp_drop = 0, exp_fd = 0, exp_known = 0;
      int          m_starve = 0, m_addr = 0;
      logic [23:0] m_data = 0, exp_rdata = 0;
      logic [23:0] mmem [8];
      bit          known [8];
      bit          rv, wv, g_rd, g_wr, oob;
      int          ra, row, col;
      logic [15:0] r, g, b;
      for (int i = 0; i < 8; i++) known[i] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         checks++;
         if (bus.rd_data_valid !== exp_dv || bus.wr_drop !== exp_drop ||
             bus.frame_done !== exp_fd || bus.wr_ready !== !m_full)
         begin errors++; $display("FAIL rnd_regs[%0d]: dv=%b drop=%b fd=%b rdy=%b want %b %b %b %b", cyc,
            bus.rd_data_valid, bus.wr_drop, bus.frame_done, bus.wr_ready, exp_dv, exp_drop, exp_fd, !m_full); end
         if (exp_dv && exp_known) begin
            checks++;
            if (bus.rd_data !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", cyc, bus.rd_data, exp_rdata); end
         end
         rv = ($urandom_range(0, 99) < 60); ra = $urandom_range(0, 7);
         wv = ($urandom_range(0, 99) < 50);
         row = $urandom_range(0, 2); col = $urandom_range(0, 4);
         r = 16'($urandom); g = 16'($urandom); b = 16'($urandom);
         bus.rd_valid = rv; bus.rd_addr = 3'(ra);
         if (wv) put_pixel(row, col, r, g, b); else bus.wr_valid = 0;
         #1;
         g_rd = rv && (!m_full || m_starve < STARVE_MAX);
         g_wr = !g_rd && m_full;
         checks++;
         if (bus.rd_ready !== g_rd || bus.mem_en !== (g_rd || g_wr) || bus.mem_we !== g_wr)
         begin errors++; $display("FAIL rnd_grant[%0d]: rdy=%b en=%b we=%b want rd=%b wr=%b", cyc, bus.rd_ready, bus.mem_en, bus.mem_we, g_rd, g_wr); end
         if (g_rd || g_wr) begin
            checks++;
            if (bus.mem_addr !== 3'(g_wr ? m_addr : ra) || (g_wr && bus.mem_wdata !== m_data))
            begin errors++; $display("FAIL rnd_bus[%0d]: addr=%0d data=%h want addr=%0d data=%h", cyc, bus.mem_addr, bus.mem_wdata, g_wr ? m_addr : ra, m_data); end
         end
         // advance model to the next edge
         exp_dv = g_rd; exp_rdata = mmem[ra]; exp_known = known[ra];
         exp_fd = g_wr && (m_addr == IMG_W * IMG_H - 1);
         if (g_wr) begin mmem[m_addr] = m_data; known[m_addr] = 1; end
         if (g_wr || !m_full) m_starve = 0;
         else if (g_rd && m_starve < STARVE_MAX) m_starve++;
         oob = (row >= IMG_H) || (col >= IMG_W);
         exp_drop = wv && !m_full && oob;
         if (wv && !m_full && !oob) begin
            m_full = 1; m_addr = row * IMG_W + col; m_data = {r[15:8], g[15:8], b[15:8]};
         end else if (g_wr) m_full = 0;
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      bus.mem_rdata = '0;
      idle_inputs();
      test_reset();
      test_write();
      test_read();
      test_starve();
      test_drop();
      test_frame_done();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
